// File: rtl/ov7670_dvp_tx.sv
`default_nettype none
// ============================================================================
// ov7670_dvp_tx : OV7670-style DVP source, RGB565 in, pclk = clk/2, high byte
// first. Optional colour-bar generator enabled by `define DVP_TX_COLORBAR_EN.
// Revision: 1.0
// ============================================================================
module ov7670_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        test_mode_i,
    input  logic [15:0] pixel_data_i,
    input  logic        pixel_valid_i,
    output logic        pixel_ready_o,
    output logic        p_clock_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  p_data_o,
    output logic        frame_start_o,
    output logic        underrun_o,
    output logic [9:0]  line_o
);

    localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW          = $clog2(LINE_LEN);

    localparam logic [HW-1:0] H_LAST      = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_BYTES     = HW'(2 * H_ACTIVE);
    localparam logic [9:0]    L_VS_END    = 10'(VSYNC_LINES - 1);
    localparam logic [9:0]    L_VB_END    = 10'(VSYNC_LINES + V_BACK - 1);
    localparam logic [9:0]    L_ACT_END   = 10'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0]    L_FRAME_END = 10'(FRAME_LINES - 1);

    generate
        if (FRAME_LINES > 1024) begin : g_frame_lines_check
            $error("FRAME_LINES does not fit the 10-bit line counter");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            pclk_q, pclk_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [9:0]      line_q, line_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      pdata_q, pdata_d;
    logic [7:0]      low_q, low_d;
    logic            fstart_q, fstart_d;
    logic            urun_q, urun_d;

    logic            w_tick;
    logic            w_start;
    logic            w_active;
    logic            w_ready;
    logic            w_cbar;
    logic [15:0]     w_pix;
    logic            w_pix_valid;

    // Timing state advances only on the clk where p_clock falls (w_tick),
    // or on the single clk that leaves IDLE.
    always_comb begin
        state_d = state_q;
        pclk_d  = pclk_q;
        hcnt_d  = hcnt_q;
        line_d  = line_q;
        w_tick  = 1'b0;
        w_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                pclk_d = 1'b0;
                if (enable_i) begin
                    state_d = S_VSYNC;
                    pclk_d  = 1'b1;
                    hcnt_d  = '0;
                    line_d  = '0;
                    w_start = 1'b1;
                end
            end
            default: begin
                pclk_d = ~pclk_q;
                if (pclk_q) begin
                    w_tick = 1'b1;
                    if (hcnt_q == H_LAST) begin
                        hcnt_d = '0;
                        line_d = (line_q == L_FRAME_END) ? 10'd0 : line_q + 10'd1;
                        case (state_q)
                            S_VSYNC:  if (line_q == L_VS_END)  state_d = S_VBACK;
                            S_VBACK:  if (line_q == L_VB_END)  state_d = S_ACTIVE;
                            S_ACTIVE: if (line_q == L_ACT_END) state_d = S_VFRONT;
                            default: begin
                                if (line_q == L_FRAME_END) begin
                                    if (enable_i) begin
                                        state_d = S_VSYNC;
                                        w_start = 1'b1;
                                    end else begin
                                        state_d = S_IDLE;
                                    end
                                end
                            end
                        endcase
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
        endcase
    end

    // Even byte slot fetches a pixel this clk; its low byte waits for the odd slot.
    always_comb begin
        vsync_d  = vsync_q;
        href_d   = href_q;
        pdata_d  = pdata_q;
        low_d    = low_q;
        fstart_d = w_start;
        urun_d   = 1'b0;
        w_ready  = 1'b0;
        w_active = (state_d == S_ACTIVE) && (hcnt_d < H_BYTES);
        if (w_start || w_tick) begin
            vsync_d = (state_d == S_VSYNC);
            href_d  = w_active;
            pdata_d = 8'h00;
            if (w_active) begin
                if (!hcnt_d[0]) begin
                    w_ready = ~w_cbar;
                    if (w_pix_valid) begin
                        pdata_d = w_pix[15:8];
                        low_d   = w_pix[7:0];
                    end else begin
                        low_d  = 8'h00;
                        urun_d = 1'b1;
                    end
                end else begin
                    pdata_d = low_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pclk_q   <= 1'b0;
            hcnt_q   <= '0;
            line_q   <= '0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            pdata_q  <= 8'h00;
            low_q    <= 8'h00;
            fstart_q <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pclk_q   <= pclk_d;
            hcnt_q   <= hcnt_d;
            line_q   <= line_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            pdata_q  <= pdata_d;
            low_q    <= low_d;
            fstart_q <= fstart_d;
            urun_q   <= urun_d;
        end
    end

`ifdef DVP_TX_COLORBAR_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic        cbar_q;
    logic [31:0] w_bar_sel;
    logic [15:0] w_bar_rgb;

    // Bar mode is frozen for the whole frame at the clk that starts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cbar_q <= 1'b0;
        end else if (w_start) begin
            cbar_q <= test_mode_i;
        end
    end

    always_comb begin
        w_bar_sel = 32'(hcnt_d[HW-1:1]) / 32'(BAR_W);
        case (w_bar_sel)
            32'd0:   w_bar_rgb = 16'hFFFF;
            32'd1:   w_bar_rgb = 16'hFFE0;
            32'd2:   w_bar_rgb = 16'h07FF;
            32'd3:   w_bar_rgb = 16'h07E0;
            32'd4:   w_bar_rgb = 16'hF81F;
            32'd5:   w_bar_rgb = 16'hF800;
            32'd6:   w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    assign w_cbar      = cbar_q;
    assign w_pix       = cbar_q ? w_bar_rgb : pixel_data_i;
    assign w_pix_valid = cbar_q | pixel_valid_i;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode_i;
    assign w_cbar      = 1'b0;
    assign w_pix       = pixel_data_i;
    assign w_pix_valid = pixel_valid_i;
`endif

    assign pixel_ready_o = w_ready;
    assign p_clock_o     = pclk_q;
    assign vsync_o       = vsync_q;
    assign href_o        = href_q;
    assign p_data_o      = pdata_q;
    assign frame_start_o = fstart_q;
    assign underrun_o    = urun_q;
    assign line_o        = line_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_dvp_tx.sv
`default_nettype none
// ============================================================================
// tb_ov7670_dvp_tx : directed bench for ov7670_dvp_tx with small frame geometry
// (LINE_LEN = 11, 5 lines per frame). Revision: 1.0
// ============================================================================
module tb_ov7670_dvp_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic        test_mode_i = 1'b0;
    logic [15:0] pixel_data_i = 16'h0000;
    logic        pixel_valid_i = 1'b0;
    logic        pixel_ready_o;
    logic        p_clock_o;
    logic        vsync_o;
    logic        href_o;
    logic [7:0]  p_data_o;
    logic        frame_start_o;
    logic        underrun_o;
    logic [9:0]  line_o;

    ov7670_dvp_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .test_mode_i(test_mode_i),
        .pixel_data_i(pixel_data_i), .pixel_valid_i(pixel_valid_i),
        .pixel_ready_o(pixel_ready_o), .p_clock_o(p_clock_o), .vsync_o(vsync_o),
        .href_o(href_o), .p_data_o(p_data_o), .frame_start_o(frame_start_o),
        .underrun_o(underrun_o), .line_o(line_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel source: value k is 0x1234 + k*0x4444; one slot per pixel_ready.
    int idx = 0;
    int slot = 0;
    int drop_slot = -1;

    initial begin
        forever begin
            @(negedge clk);
            pixel_valid_i = (slot != drop_slot);
            pixel_data_i  = 16'h1234 + 16'(idx) * 16'h4444;
            if (pixel_ready_o) begin
                if (pixel_valid_i) idx++;
                slot++;
            end
        end
    end

    // Monitor: snapshot outputs once per p_clock period, indexed from frame start.
    int   cyc = 0, pcnt = 1000, fs_count = 0, ur_count = 0, rdy_count = 0, rise_count = 0;
    int   vs_run = 0, vs_len = 0, fs_t_prev = 0, fs_t_last = 0;
    logic prev_pclk = 1'b0, prev_vs = 1'b0, armed = 1'b0;
    logic       snap_vs [0:54];
    logic       snap_hr [0:54];
    logic [7:0] snap_d  [0:54];
    logic [9:0] snap_ln [0:54];

    always @(negedge clk) begin
        cyc++;
        if (frame_start_o) begin
            fs_count++;
            fs_t_prev = fs_t_last;
            fs_t_last = cyc;
            armed = 1'b1;
        end
        if (underrun_o) ur_count++;
        if (pixel_ready_o) rdy_count++;
        if (vsync_o) vs_run++;
        else if (prev_vs) begin
            vs_len = vs_run;
            vs_run = 0;
        end
        prev_vs = vsync_o;
        if (p_clock_o && !prev_pclk) begin
            rise_count++;
            if (armed) begin
                pcnt = 0;
                armed = 1'b0;
            end else begin
                pcnt++;
            end
            if (pcnt < 55) begin
                snap_vs[pcnt] = vsync_o;
                snap_hr[pcnt] = href_o;
                snap_d[pcnt]  = p_data_o;
                snap_ln[pcnt] = line_o;
            end
        end
        prev_pclk = p_clock_o;
    end

    task automatic do_reset();
        enable_i = 1'b0;
        test_mode_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        fs_count = 0; ur_count = 0; rdy_count = 0; rise_count = 0;
        pcnt = 1000; armed = 1'b0;
    endtask

    task automatic start_frame(input int drop, input logic tm);
        @(negedge clk);
        #2;
        idx = 0;
        slot = 0;
        drop_slot = drop;
        test_mode_i = tm;
        enable_i = 1'b1;
    endtask

    task automatic wait_frame(input string name);
        int k;
        k = 0;
        while (!(fs_count >= 1 && pcnt == 54) && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk(name, 32'(pcnt == 54), 32'd1);
    endtask

    typedef struct {
        int         drop;
        int         n;
        logic       hr;
        logic [7:0] d;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] a2 [0:7];
        logic [7:0] a3 [0:7];
        logic [7:0] b2 [0:7];
        logic [7:0] b3 [0:7];
        int         scen [0:1];
        int         bad, k, fs_snap, rise_snap;

        a2 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDF, 8'h00};
        a3 = '{8'h23, 8'h44, 8'h67, 8'h88, 8'hAB, 8'hCC, 8'hF0, 8'h10};
        b2 = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h56, 8'h78, 8'h9A, 8'hBC};
        b3 = '{8'hDF, 8'h00, 8'h23, 8'h44, 8'h67, 8'h88, 8'hAB, 8'hCC};
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{drop: -1, n: 22 + i, hr: 1'b1, d: a2[i]});
            vecs.push_back('{drop: -1, n: 33 + i, hr: 1'b1, d: a3[i]});
            vecs.push_back('{drop: 1,  n: 22 + i, hr: 1'b1, d: b2[i]});
            vecs.push_back('{drop: 1,  n: 33 + i, hr: 1'b1, d: b3[i]});
        end
        vecs.push_back('{drop: -1, n: 21, hr: 1'b0, d: 8'h00});
        vecs.push_back('{drop: -1, n: 30, hr: 1'b0, d: 8'h00});
        vecs.push_back('{drop: -1, n: 41, hr: 1'b0, d: 8'h00});
        vecs.push_back('{drop: -1, n: 44, hr: 1'b0, d: 8'h00});
        vecs.push_back('{drop: 1,  n: 10, hr: 1'b0, d: 8'h00});
        vecs.push_back('{drop: 1,  n: 31, hr: 1'b0, d: 8'h00});
        scen = '{-1, 1};

        #1;
        chk("reset_outputs",
            {19'd0, p_clock_o, vsync_o, href_o, p_data_o, pixel_ready_o, frame_start_o, underrun_o},
            32'd0);
        chk("reset_line", 32'(line_o), 32'd0);

        for (int s = 0; s < 2; s++) begin
            do_reset();
            start_frame(scen[s], 1'b0);
            wait_frame($sformatf("frame_done_drop%0d", scen[s]));
            foreach (vecs[i]) begin
                if (vecs[i].drop == scen[s]) begin
                    chk($sformatf("href_n%0d_drop%0d", vecs[i].n, scen[s]),
                        32'(snap_hr[vecs[i].n]), 32'(vecs[i].hr));
                    chk($sformatf("pdata_n%0d_drop%0d", vecs[i].n, scen[s]),
                        32'(snap_d[vecs[i].n]), 32'(vecs[i].d));
                end
            end
            chk($sformatf("underruns_drop%0d", scen[s]), 32'(ur_count), (scen[s] < 0) ? 32'd0 : 32'd1);
            if (scen[s] < 0) begin
                bad = 0;
                for (int n = 0; n < 55; n++) begin
                    if (snap_vs[n] !== (n < 11)) bad++;
                    if (snap_ln[n] !== 10'(n / 11)) bad++;
                end
                chk("vsync_line_sweep_bad", 32'(bad), 32'd0);
                k = 0;
                while (fs_count < 3 && k < 400) begin
                    @(negedge clk);
                    #2;
                    k++;
                end
                chk("third_frame_start_seen", 32'(fs_count >= 3), 32'd1);
                chk("frame_start_spacing", 32'(fs_t_last - fs_t_prev), 32'd110);
                chk("vsync_high_clks", 32'(vs_len), 32'd22);
            end
        end

        // Enable dropped in line 2: frame completes, then stays idle.
        do_reset();
        start_frame(-1, 1'b0);
        k = 0;
        while (line_o != 10'd2 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("drop_reached_line2", 32'(line_o), 32'd2);
        enable_i = 1'b0;
        wait_frame("drop_frame_completes");
        repeat (10) @(negedge clk);
        #2;
        fs_snap = fs_count;
        rise_snap = rise_count;
        chk("drop_idle_outputs", {20'd0, p_clock_o, vsync_o, href_o, p_data_o, frame_start_o}, 32'd0);
        repeat (150) @(negedge clk);
        #2;
        chk("drop_no_restart", 32'(fs_count), 32'(fs_snap));
        chk("drop_pclk_stopped", 32'(rise_count - rise_snap), 32'd0);
        chk("drop_frame_count", 32'(fs_count), 32'd1);

        // Asynchronous reset in the active region.
        do_reset();
        start_frame(-1, 1'b0);
        k = 0;
        while (href_o != 1'b1 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("rst_reached_active", 32'(href_o), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {19'd0, p_clock_o, vsync_o, href_o, p_data_o, pixel_ready_o, frame_start_o, underrun_o},
            32'd0);
        chk("async_reset_line", 32'(line_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_pclk_vsync_fs", {29'd0, p_clock_o, vsync_o, frame_start_o}, 32'd7);
        chk("restart_line", 32'(line_o), 32'd0);

`ifdef DVP_TX_COLORBAR_EN
        begin
            logic [7:0] cb [0:7];
            cb = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0};
            do_reset();
            start_frame(-1, 1'b1);
            @(negedge clk);
            #2;
            test_mode_i = 1'b0;
            wait_frame("cbar_frame_done");
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("cbar_l2_b%0d", i), 32'(snap_d[22 + i]), 32'(cb[i]));
                chk($sformatf("cbar_l3_b%0d", i), 32'(snap_d[33 + i]), 32'(cb[i]));
            end
            chk("cbar_ready_pulses", 32'(rdy_count), 32'd0);
            chk("cbar_underruns", 32'(ur_count), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ov7670_dvp_tx.md
# ov7670_dvp_tx

Transmit-side OV7670-style DVP source: takes a 16-bit RGB565 pixel stream and drives pclk, vsync, href and an 8-bit data bus exactly as the sensor does, two bytes per pixel, high byte first. It is the other end of the camera capture path. It serves as a sensor emulator for loopback testing of the capture logic and as a DVP output to downstream boards. All timing is derived from the single system clock, and pclk runs at clk/2.

## Interface
- H_ACTIVE, 640: active pixels per line (bytes per line = 2*H_ACTIVE)
- V_ACTIVE, 480: active lines per frame
- H_BLANK, 144: pclk periods with href low after the active bytes of each line
- VSYNC_LINES, 3: lines with vsync high at frame start
- V_BACK, 17: blank lines after vsync
- V_FRONT, 10: blank lines after active lines
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- enable  in  1  start/continue frame generation
- test_mode  in  1  select internal colour bars (see Configuration)
- pixel_data  in  16  RGB565 pixel, [15:8] sent first
- pixel_valid  in  1  pixel_data valid
- pixel_ready  out  1  pixel accepted when pixel_valid & pixel_ready
- p_clock  out  1  DVP pixel clock
- vsync  out  1  frame sync, active high
- href  out  1  line valid
- p_data  out  8  DVP data byte
- frame_start  out  1  one-clk pulse on vsync rising
- underrun  out  1  one-clk pulse when a needed pixel was not valid
- line  out  10  current line index within frame

## Operation
- LINE_LEN = 2*H_ACTIVE + H_BLANK pclk periods; FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT.
- hcnt (0..LINE_LEN-1) counts pclk periods and wraps to 0 with line++. line wraps at FRAME_LINES-1.
- States:
  - IDLE: p_clock held 0, all outputs low. Go to VSYNC when enable=1.
  - VSYNC: vsync=1 for VSYNC_LINES lines, then VBACK.
  - VBACK: V_BACK lines, then ACTIVE.
  - ACTIVE: V_ACTIVE lines with href=1 for hcnt < 2*H_ACTIVE, then VFRONT.
  - VFRONT: V_FRONT lines, then VSYNC if enable=1, else IDLE.
- Bytes in a line:
  - Even hcnt: high byte. pixel_ready=1 for that one clk.
  - If pixel_valid, pixel_data is accepted; [15:8] goes out now and [7:0] is held for the odd slot.
  - If not valid, 0x0000 is sent and underrun pulses.
  - Odd hcnt: the held low byte.
- p_data = 0 whenever href = 0.
- enable is sampled only at the end of VFRONT, so a frame always completes. Dropping enable never truncates a frame.

## Timing
- While not IDLE, p_clock toggles every clk.
- vsync, href, p_data, line and the counters update only on the clk where p_clock goes 1->0, so they are stable across every p_clock rising edge.
- Entering VSYNC from IDLE:
  - The clk that sees enable=1 sets p_clock=1, vsync=1 and frame_start=1.
  - The next clk takes p_clock to 0.
- pixel_ready is asserted in the same clk that drives the high byte. Data is sampled combinationally from pixel_data in that clk; there is no skid buffer.
- One pixel = 4 clk; one line = 2*LINE_LEN clk.
- Reset values: p_clock=0, vsync=0, href=0, p_data=0, pixel_ready=0, frame_start=0, underrun=0, line=0, state=IDLE. Reset asserted mid-frame forces these immediately; after release, generation restarts from IDLE.
- Width rules:
  - hcnt is sized to clog2(LINE_LEN).
  - line is 10 bits.
  - FRAME_LINES must be ≤ 1024; this is checked at elaboration.

## Configuration
- DVP_TX_COLORBAR_EN defined:
  - test_mode=1 replaces the pixel stream with 8 vertical bars, each H_ACTIVE/8 pixels wide.
  - Bar order: white 0xFFFF, yellow 0xFFE0, cyan 0x07FF, green 0x07E0, magenta 0xF81F, red 0xF800, blue 0x001F, black 0x0000.
  - pixel_ready is held 0 and underrun never pulses.
  - test_mode is sampled at frame start only.
- DVP_TX_COLORBAR_EN undefined: test_mode is ignored and the bar logic is not built.

## Test plan
Small parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_LEN=11 and a frame of 5 lines = 110 clk.

- Framing: enable=1 with an always-valid incrementing source.
  - Required: vsync high for 22 clk, then href high for 8 p_clock periods on lines 2 and 3 only.
  - Required: frame_start pulses every 110 clk.
- Byte order: source 0x1234, 0x5678, ... -> p_data sampled on p_clock rising reads 0x12, 0x34, 0x56, 0x78.
- Underrun: pixel_valid=0 for the 2nd pixel of line 2 -> bytes 0x00, 0x00, one underrun pulse, and following pixels still sent in order.
- Enable drop: enable=0 during line 2 -> frame finishes through VFRONT, then IDLE with p_clock=0 and no further frame_start.
- Reset mid-frame: rst pulse during ACTIVE -> all outputs 0 asynchronously; after release with enable=1, vsync rises with frame_start and line=0.
- Colour bars (macro defined, test_mode=1): each line carries FFFF, FFE0... at 0.5 pixel per bar width rounded to 1, checked as 0xFFFF, 0xFFE0, 0x07FF, 0x07E0 for H_ACTIVE=4 (first four bars). pixel_ready stays 0.
